// File: rtl/sdram_model_pkg.sv
// Shared encodings for the SDRAM device model: commands, bank state,
// sticky error bit positions and mode-register fields.
package sdram_model_pkg;

    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_NOP       = 3'b111;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    localparam int ERR_IDLE_ACCESS = 0;
    localparam int ERR_ACT_OPEN    = 1;
    localparam int ERR_TRCD        = 2;
    localparam int ERR_TRRD_TRP    = 3;
    localparam int ERR_REF_OPEN    = 4;
    localparam int ERR_STARVE      = 5;
    localparam int ERR_CONTENTION  = 6;
    localparam int ERR_PROTOCOL    = 7;

    localparam int MR_BL_LSB = 0;
    localparam int MR_BL_MSB = 2;
    localparam int MR_CL_LSB = 4;
    localparam int MR_CL_MSB = 6;

    // Only burst length 1 and CAS latency 2 or 3 are modelled.
    function automatic logic mode_ok(input logic [12:0] a);
        return (a[MR_BL_MSB:MR_BL_LSB] == 3'd0) &&
               ((a[MR_CL_MSB:MR_CL_LSB] == 3'd2) || (a[MR_CL_MSB:MR_CL_LSB] == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: IDLE/ACTIVE state, open row, tRCD/tRP timers and the
// deferred auto-precharge; flags per-bank protocol violations.
module sdram_model_bank
    import sdram_model_pkg::*;
#(
    parameter int TRCD = 2,
    parameter int TRP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        act_i,
    input  logic        pre_i,
    input  logic        acc_i,
    input  logic        ap_i,
    input  logic [12:0] row_i,
    output logic        open_o,
    output logic [12:0] row_o,
    output logic        err_idle_o,
    output logic        err_open_o,
    output logic        err_rcd_o,
    output logic        err_rp_o
);

    bank_state_e state_q, state_d;
    logic [7:0]  rcd_q, rcd_d;
    logic [7:0]  rp_q, rp_d;
    logic        ap_q, ap_d;
    logic [12:0] row_q, row_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BANK_IDLE;
            rcd_q   <= '0;
            rp_q    <= '0;
            ap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rcd_q   <= rcd_d;
            rp_q    <= rp_d;
            ap_q    <= ap_d;
        end
        row_q <= row_d;
    end

    // Timers load N-1 so an access exactly N edges later sees zero.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rcd_d   = (rcd_q != '0) ? rcd_q - 8'd1 : '0;
        rp_d    = (rp_q != '0) ? rp_q - 8'd1 : '0;
        ap_d    = 1'b0;
        if (ap_q) begin
            state_d = BANK_IDLE;
            rp_d    = 8'(TRP - 1);
        end else begin
            case (state_q)
                BANK_IDLE: begin
                    if (act_i) begin
                        state_d = BANK_ACTIVE;
                        row_d   = row_i;
                        rcd_d   = 8'(TRCD - 1);
                    end
                end
                BANK_ACTIVE: begin
                    if (pre_i) begin
                        state_d = BANK_IDLE;
                        rp_d    = 8'(TRP - 1);
                    end else if (acc_i && ap_i) begin
                        ap_d = 1'b1;
                    end
                end
                default: state_d = BANK_IDLE;
            endcase
        end
    end

    always_comb begin
        open_o     = (state_q == BANK_ACTIVE);
        row_o      = row_q;
        err_idle_o = acc_i && (state_q != BANK_ACTIVE);
        err_open_o = act_i && (state_q == BANK_ACTIVE);
        err_rcd_o  = acc_i && (state_q == BANK_ACTIVE) && (rcd_q != '0);
        err_rp_o   = act_i && (state_q != BANK_ACTIVE) && (rp_q != '0);
    end

endmodule

// File: rtl/sdram_device_model.sv
// Cycle-accurate x16 SDR SDRAM responder: command decode, backing store,
// CAS-latency read pipeline and sticky protocol/timing error flags.
module sdram_device_model
    import sdram_model_pkg::*;
#(
    parameter int          MEM_AW      = 16,
    parameter int          TRCD        = 2,
    parameter int          TRRD        = 2,
    parameter int          TRP         = 2,
    parameter logic [15:0] REFRESH_MAX = 16'd624
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_count,
    output logic [7:0]  err
);

    function automatic logic [15:0] apply_dqm(input logic [15:0] w, input logic [1:0] m);
        return {m[1] ? 8'h00 : w[15:8], m[0] ? 8'h00 : w[7:0]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0] cmd;
    logic       is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_nop;
    logic [3:0] bank_sel, b_open, b_err_idle, b_err_open, b_err_rcd, b_err_rp;
    logic [12:0] bank_row [4];

    always_comb begin
        cmd    = sd_ncs ? CMD_NOP : {sd_nras, sd_ncas, sd_nwe};
        is_act = (cmd == CMD_ACTIVE);
        is_rd  = (cmd == CMD_READ);
        is_wr  = (cmd == CMD_WRITE);
        is_pre = (cmd == CMD_PRECHARGE);
        is_ref = (cmd == CMD_REFRESH);
        is_lmr = (cmd == CMD_LOAD_MODE);
        is_nop = (cmd == CMD_NOP);
        bank_sel = 4'b0001 << sd_ba;
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_model_bank #(.TRCD(TRCD), .TRP(TRP)) u_bank (
            .clk       (clk),
            .reset     (reset),
            .act_i     (is_act && bank_sel[g]),
            .pre_i     (is_pre && (sd_a[10] || bank_sel[g])),
            .acc_i     ((is_rd || is_wr) && bank_sel[g]),
            .ap_i      (sd_a[10]),
            .row_i     (sd_a),
            .open_o    (b_open[g]),
            .row_o     (bank_row[g]),
            .err_idle_o(b_err_idle[g]),
            .err_open_o(b_err_open[g]),
            .err_rcd_o (b_err_rcd[g]),
            .err_rp_o  (b_err_rp[g])
        );
    end

    logic [MEM_AW-1:0] mem_addr;
    logic              wr_en, rd_en;
    logic [15:0]       rd_word;
    logic [15:0]       mem_q [2**MEM_AW];

    assign mem_addr = MEM_AW'({sd_ba, bank_row[sd_ba], sd_a[8:0]});
    assign wr_en    = is_wr && b_open[sd_ba];
    assign rd_en    = is_rd && b_open[sd_ba];
    assign rd_word  = mem_q[mem_addr];

    always_ff @(posedge clk) begin
        if (wr_en && !sd_dqml) mem_q[mem_addr][7:0]  <= dq_in[7:0];
        if (wr_en && !sd_dqmh) mem_q[mem_addr][15:8] <= dq_in[15:8];
    end

    logic [3:0]  trrd_q, trrd_d;
    logic [1:0]  last_ba_q, last_ba_d;
    logic        pre_all_q, pre_all_d, init_q, init_d;
    logic [1:0]  aref_q, aref_d, dqm_q, dqm_d;
    logic [12:0] mode_q, mode_d;
    logic [15:0] refcnt_q, refcnt_d, refint_q, refint_d;
    logic [7:0]  err_q, err_d;
    logic [1:0]  pipe_vld_q, pipe_vld_d;
    logic [15:0] pipe_data_q [2];
    logic [15:0] pipe_data_d [2];
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        cl3;

    always_comb begin
        cl3       = (mode_q[MR_CL_MSB:MR_CL_LSB] == 3'd3);
        trrd_d    = is_act ? 4'(TRRD - 1) : ((trrd_q != '0) ? trrd_q - 4'd1 : '0);
        last_ba_d = is_act ? sd_ba : last_ba_q;
        pre_all_d = pre_all_q || (is_pre && sd_a[10]);
        aref_d    = (is_ref && pre_all_q && aref_q != 2'd3) ? aref_q + 2'd1 : aref_q;
        init_d    = init_q || (is_lmr && pre_all_q && aref_q >= 2'd2);
        mode_d    = is_lmr ? sd_a : mode_q;
        refcnt_d  = refcnt_q + {15'd0, is_ref};
        refint_d  = is_ref ? 16'd0 : sat_inc(refint_q);
        dqm_d     = {sd_dqmh, sd_dqml};

        err_d = err_q;
        err_d[ERR_IDLE_ACCESS] = err_q[ERR_IDLE_ACCESS] | (|b_err_idle);
        err_d[ERR_ACT_OPEN]    = err_q[ERR_ACT_OPEN] | (|b_err_open);
        err_d[ERR_TRCD]        = err_q[ERR_TRCD] | (|b_err_rcd);
        err_d[ERR_TRRD_TRP]    = err_q[ERR_TRRD_TRP] | (|b_err_rp) |
                                 (is_act && trrd_q != '0 && sd_ba != last_ba_q);
        err_d[ERR_REF_OPEN]    = err_q[ERR_REF_OPEN] | ((is_ref || is_lmr) && (|b_open));
        err_d[ERR_STARVE]      = err_q[ERR_STARVE] | (init_q && refint_q > REFRESH_MAX);
        err_d[ERR_CONTENTION]  = err_q[ERR_CONTENTION] | (is_wr && dq_oe_q);
        err_d[ERR_PROTOCOL]    = err_q[ERR_PROTOCOL] |
                                 (!init_q && !(is_nop || is_pre || is_ref || is_lmr)) |
                                 (is_lmr && !mode_ok(sd_a));

        // CL3 reads enter one stage earlier than CL2 reads.
        pipe_vld_d[0]  = rd_en && cl3;
        pipe_data_d[0] = rd_word;
        pipe_vld_d[1]  = (rd_en && !cl3) ? 1'b1 : pipe_vld_q[0];
        pipe_data_d[1] = (rd_en && !cl3) ? rd_word : pipe_data_q[0];
        dq_oe_d        = pipe_vld_q[1];
        dq_out_d       = pipe_vld_q[1] ? apply_dqm(pipe_data_q[1], dqm_q) : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trrd_q     <= '0;
            last_ba_q  <= '0;
            pre_all_q  <= 1'b0;
            aref_q     <= '0;
            init_q     <= 1'b0;
            mode_q     <= '0;
            refcnt_q   <= '0;
            refint_q   <= '0;
            err_q      <= '0;
            dqm_q      <= '0;
            pipe_vld_q <= '0;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
        end else begin
            trrd_q     <= trrd_d;
            last_ba_q  <= last_ba_d;
            pre_all_q  <= pre_all_d;
            aref_q     <= aref_d;
            init_q     <= init_d;
            mode_q     <= mode_d;
            refcnt_q   <= refcnt_d;
            refint_q   <= refint_d;
            err_q      <= err_d;
            dqm_q      <= dqm_d;
            pipe_vld_q <= pipe_vld_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
        end
        pipe_data_q[0] <= pipe_data_d[0];
        pipe_data_q[1] <= pipe_data_d[1];
    end

    assign dq_out        = dq_out_q;
    assign dq_oe         = dq_oe_q;
    assign init_done     = init_q;
    assign mode_reg      = mode_q;
    assign refresh_count = refcnt_q;
    assign err           = err_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Bench for the SDRAM device model: table-driven write/read vectors,
// scoreboarded read data, and hand-written timing/violation sequences.
module tb_sdram_device_model;
    import sdram_model_pkg::*;

    logic        clk, reset;
    logic        sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_dqml, sd_dqmh;
    logic [1:0]  sd_ba;
    logic [12:0] sd_a;
    logic [15:0] dq_in, dq_out, refresh_count;
    logic        dq_oe, init_done;
    logic [12:0] mode_reg;
    logic [7:0]  err;

    sdram_device_model dut (
        .clk(clk), .reset(reset), .sd_ncs(sd_ncs), .sd_nras(sd_nras),
        .sd_ncas(sd_ncas), .sd_nwe(sd_nwe), .sd_ba(sd_ba), .sd_a(sd_a),
        .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .init_done(init_done), .mode_reg(mode_reg),
        .refresh_count(refresh_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0]  ba;
        logic [12:0] row;
        logic [8:0]  col;
        logic        wen;
        logic [15:0] wdata;
        logic [1:0]  wdqm;
        logic [1:0]  rdqm;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[6];

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endfunction

    // Read-data scoreboard: every dq_oe cycle must match the oldest pending read.
    always @(negedge clk) begin
        if (dq_oe) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dq_oe got dq_out=%h want no data", dq_out);
            end else begin
                mon_e = sbq.pop_front();
                check("rd_data", {16'd0, dq_out}, {16'd0, mon_e.data});
                check("rd_edge", edge_n, mon_e.due);
            end
        end else if (sbq.size() != 0 && sbq[0].due < edge_n) begin
            total++;
            bad++;
            $display("FAIL missing_read got no dq_oe want data=%h at edge %0d", sbq[0].data, sbq[0].due);
            mon_e = sbq.pop_front();
        end
    end

    task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] dqm);
        sd_ncs = 1'b0;
        {sd_nras, sd_ncas, sd_nwe} = c;
        sd_ba = ba;
        sd_a  = a;
        dq_in = d;
        {sd_dqmh, sd_dqml} = dqm;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(CMD_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] a, input logic [1:0] dqm,
                      input logic [15:0] exp, input int cl);
        exp_t e;
        drive(CMD_READ, ba, a, 16'd0, dqm);
        e.data = exp;
        e.due  = edge_n + cl - 1;
        sbq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    initial begin
        int exp_ref;
        vt[0] = '{2'd0, 13'd5,      9'd3,    1'b1, 16'hA55A, 2'b00, 2'b00, 16'hA55A};
        vt[1] = '{2'd1, 13'd7,      9'd10,   1'b1, 16'hFFFF, 2'b00, 2'b00, 16'hFFFF};
        vt[2] = '{2'd1, 13'd7,      9'd10,   1'b1, 16'h1234, 2'b10, 2'b00, 16'hFF34};
        vt[3] = '{2'd1, 13'd7,      9'd10,   1'b0, 16'h0000, 2'b00, 2'b01, 16'hFF00};
        vt[4] = '{2'd2, 13'h1ABC,   9'h1FF,  1'b1, 16'h5AA5, 2'b00, 2'b10, 16'h00A5};
        vt[5] = '{2'd3, 13'd3,      9'd0,    1'b1, 16'h0F0F, 2'b00, 2'b00, 16'h0F0F};

        reset = 1'b1;
        sd_ncs = 1'b1; {sd_nras, sd_ncas, sd_nwe} = 3'b111;
        sd_ba = '0; sd_a = '0; dq_in = '0; sd_dqml = 1'b0; sd_dqmh = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_dq_oe", {31'd0, dq_oe}, 0);
        check("rst_dq_out", {16'd0, dq_out}, 0);
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_mode_reg", {19'd0, mode_reg}, 0);
        check("rst_refresh_count", {16'd0, refresh_count}, 0);
        check("rst_err", {24'd0, err}, 0);

        // Init sequence
        drive(CMD_PRECHARGE, 2'd0, 13'h400, 16'd0, 2'b00);
        drive(CMD_REFRESH, 2'd0, 13'd0, 16'd0, 2'b00);
        drive(CMD_REFRESH, 2'd0, 13'd0, 16'd0, 2'b00);
        check("pre_lmr_init_done", {31'd0, init_done}, 0);
        drive(CMD_LOAD_MODE, 2'd0, 13'h220, 16'd0, 2'b00);
        nop(1);
        exp_ref = 2;
        check("init_done", {31'd0, init_done}, 1);
        check("init_mode_reg", {19'd0, mode_reg}, 32'h220);
        check("init_refresh_count", {16'd0, refresh_count}, exp_ref);
        check("init_err", {24'd0, err}, 0);

        // Table-driven write then auto-precharged read at CL2
        for (int v = 0; v < 6; v++) begin
            drive(CMD_ACTIVE, vt[v].ba, vt[v].row, 16'd0, 2'b00);
            nop(1);
            if (vt[v].wen)
                drive(CMD_WRITE, vt[v].ba, {4'b0010, vt[v].col}, vt[v].wdata, vt[v].wdqm);
            else
                drive(CMD_PRECHARGE, vt[v].ba, 13'd0, 16'd0, 2'b00);
            nop(2);
            drive(CMD_ACTIVE, vt[v].ba, vt[v].row, 16'd0, 2'b00);
            nop(1);
            rd(vt[v].ba, {4'b0010, vt[v].col}, vt[v].rdqm, vt[v].exp, 2);
            nop(3);
            check("vec_err", {24'd0, err}, 0);
        end

        // CL3 back-to-back reads on two banks
        drive(CMD_LOAD_MODE, 2'd0, 13'h230, 16'd0, 2'b00);
        check("cl3_mode_reg", {19'd0, mode_reg}, 32'h230);
        drive(CMD_ACTIVE, 2'd0, 13'd5, 16'd0, 2'b00);
        nop(1);
        drive(CMD_ACTIVE, 2'd1, 13'd7, 16'd0, 2'b00);
        nop(1);
        rd(2'd0, 13'd3, 2'b00, 16'hA55A, 3);
        rd(2'd1, 13'd10, 2'b00, 16'hFF34, 3);
        nop(4);
        drive(CMD_PRECHARGE, 2'd0, 13'h400, 16'd0, 2'b00);
        nop(2);
        check("cl3_err", {24'd0, err}, 0);

        // Refresh starvation
        drive(CMD_REFRESH, 2'd0, 13'd0, 16'd0, 2'b00);
        exp_ref++;
        check("ref_count", {16'd0, refresh_count}, exp_ref);
        nop(600);
        check("starve_early", {31'd0, err[ERR_STARVE]}, 0);
        nop(30);
        check("starve_set", {31'd0, err[ERR_STARVE]}, 1);
        drive(CMD_REFRESH, 2'd0, 13'd0, 16'd0, 2'b00);
        exp_ref++;
        nop(2);
        check("starve_sticky", {31'd0, err[ERR_STARVE]}, 1);
        check("ref_count2", {16'd0, refresh_count}, exp_ref);

        // tRCD violation: access still performed
        drive(CMD_ACTIVE, 2'd0, 13'd5, 16'd0, 2'b00);
        rd(2'd0, 13'h403, 2'b00, 16'hA55A, 3);
        nop(4);
        check("trcd_err", {24'd0, err}, 32'h24);

        // READ to an idle bank is ignored
        drive(CMD_READ, 2'd3, 13'd0, 16'd0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            check("idle_rd_oe", {31'd0, dq_oe}, 0);
            nop(1);
        end
        check("idle_rd_err", {24'd0, err}, 32'h25);

        // Reset one edge after a READ flushes the pipeline
        drive(CMD_ACTIVE, 2'd0, 13'd5, 16'd0, 2'b00);
        nop(2);
        drive(CMD_READ, 2'd0, 13'd3, 16'd0, 2'b00);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nop(1);
            if (i == 1) reset = 1'b0;
            check("rst_mid_read_oe", {31'd0, dq_oe}, 0);
        end
        check("rst_mid_read_err", {24'd0, err}, 0);
        check("rst_mid_read_init", {31'd0, init_done}, 0);
        check("rst_mid_read_refcnt", {16'd0, refresh_count}, 0);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) nop(1);
        check("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
